// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Contents: transmitter FSM state encoding, register offsets relative
// to BASE_ADDR, STATUS bit positions, and a helper that assembles the
// 64-bit STATUS word.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam logic [63:0] TXDATA_OFS = 64'd0;
  localparam logic [63:0] STATUS_OFS = 64'd8;

  localparam int STATUS_BUSY_BIT  = 0;
  localparam int STATUS_FULL_BIT  = 1;
  localparam int STATUS_EMPTY_BIT = 2;
  localparam int STATUS_OVF_BIT   = 3;
  localparam int STATUS_COUNT_LSB = 8;

  // Builds the STATUS word; every bit not named here reads as zero.
  function automatic logic [63:0] pack_status(input logic       busy,
                                              input logic       full,
                                              input logic       empty,
                                              input logic       ovf,
                                              input logic [7:0] count);
    logic [63:0] s;
    s = '0;
    s[STATUS_BUSY_BIT]          = busy;
    s[STATUS_FULL_BIT]          = full;
    s[STATUS_EMPTY_BIT]         = empty;
    s[STATUS_OVF_BIT]           = ovf;
    s[STATUS_COUNT_LSB +: 8]    = count;
    return s;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read data.
// Ports:
//   clk_i    clock
//   rst_ni   asynchronous active-low reset (empties the FIFO)
//   push_i   write request; ignored while full
//   data_i   write data
//   pop_i    read request; ignored while empty
//   data_o   entry at the read pointer (valid while not empty)
//   full_o   count equals DEPTH
//   empty_o  count equals zero
//   count_o  number of stored entries, log2(DEPTH)+1 bits
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q, rdPtr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             doPush, doPop;

  // Fullness and emptiness come from the pre-edge count, so a pop in the
  // same cycle never makes room for a push into a full FIFO.
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;
  assign data_o  = mem_q[rdPtr_q];
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    unique case ({doPush, doPop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk_i) begin
    if (doPush) mem_q[wrPtr_q] <= data_i;
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + AW'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + AW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter (8N1) on the data-memory bus.
// Stores to TXDATA queue a byte; a side-effect-free STATUS register at
// BASE_ADDR+8 reports busy/full/empty/overflow/count.
// Ports:
//   clk     core clock
//   resetn  asynchronous active-low reset
//   addr    memory-stage byte address
//   wdata   memory-stage store data
//   wmem    memory write enable
//   funct3  access size code (not used by this device)
//   hit     combinational: addr selects TXDATA or STATUS
//   rdata   combinational STATUS read data, zero for other addresses
//   txd     serial output, idle high
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR  = 64'h0000_0000_0001_0000,
  parameter int          BAUD_DIV   = 868,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  input  logic        wmem,
  input  logic [2:0]  funct3,
  output logic        hit,
  output logic [63:0] rdata,
  output logic        txd
);

  localparam int          CW          = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] BAUD_RELOAD = 16'(BAUD_DIV - 1);
  localparam logic [63:0] TXDATA_ADDR = BASE_ADDR + TXDATA_OFS;
  localparam logic [63:0] STATUS_ADDR = BASE_ADDR + STATUS_OFS;

  logic          selData, selStatus, dataWrite, statusWrite;
  logic          fifoPop, fifoFull, fifoEmpty;
  logic [7:0]    fifoData;
  logic [CW-1:0] fifoCount;
  tx_state_e     state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bitIdx_q, bitIdx_d;
  logic [15:0]   baudCnt_q, baudCnt_d;
  logic          overflow_q, overflow_d;
  logic          txd_q, txd_d;
  logic          bitDone;
  logic          unused_inputs;

  assign selData     = (addr == TXDATA_ADDR);
  assign selStatus   = (addr == STATUS_ADDR);
  assign hit         = selData | selStatus;
  assign dataWrite   = wmem && selData;
  assign statusWrite = wmem && selStatus;
  assign unused_inputs = ^{funct3, wdata[63:8]};

  assign rdata = selStatus ? pack_status(state_q != IDLE, fifoFull, fifoEmpty,
                                         overflow_q, 8'(fifoCount))
                           : 64'd0;

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk),
    .rst_ni (resetn),
    .push_i (dataWrite),
    .data_i (wdata[7:0]),
    .pop_i  (fifoPop),
    .data_o (fifoData),
    .full_o (fifoFull),
    .empty_o(fifoEmpty),
    .count_o(fifoCount)
  );

  // A store that finds the FIFO full is lost; the sticky flag records it
  // until software writes STATUS with bit 3 set.
  always_comb begin
    overflow_d = overflow_q;
    if (dataWrite && fifoFull)           overflow_d = 1'b1;
    else if (statusWrite && wdata[3])    overflow_d = 1'b0;
  end

  assign bitDone = (baudCnt_q == 16'd0);

  // Next-state logic. STOP pops the next byte directly into START so
  // queued frames follow each other without an idle bit.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bitIdx_d  = bitIdx_q;
    baudCnt_d = baudCnt_q;
    fifoPop   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifoEmpty) begin
          fifoPop   = 1'b1;
          shift_d   = fifoData;
          state_d   = START;
          baudCnt_d = BAUD_RELOAD;
        end
      end
      START: begin
        if (bitDone) begin
          state_d   = DATA;
          bitIdx_d  = 3'd0;
          baudCnt_d = BAUD_RELOAD;
        end else begin
          baudCnt_d = baudCnt_q - 16'd1;
        end
      end
      DATA: begin
        if (bitDone) begin
          shift_d   = {1'b0, shift_q[7:1]};
          baudCnt_d = BAUD_RELOAD;
          if (bitIdx_q == 3'd7) state_d  = STOP;
          else                  bitIdx_d = bitIdx_q + 3'd1;
        end else begin
          baudCnt_d = baudCnt_q - 16'd1;
        end
      end
      STOP: begin
        if (bitDone) begin
          if (!fifoEmpty) begin
            fifoPop   = 1'b1;
            shift_d   = fifoData;
            state_d   = START;
            baudCnt_d = BAUD_RELOAD;
          end else begin
            state_d   = IDLE;
          end
        end else begin
          baudCnt_d = baudCnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // txd is registered from the next state so the pin is glitch-free,
  // and its asynchronous preset drives it high the moment reset asserts.
  always_comb begin
    txd_d = 1'b1;
    unique case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bitIdx_q   <= '0;
      baudCnt_q  <= '0;
      overflow_q <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bitIdx_q   <= bitIdx_d;
      baudCnt_q  <= baudCnt_d;
      overflow_q <= overflow_d;
      txd_q      <= txd_d;
    end
  end

  assign txd = txd_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx (BAUD_DIV=4, FIFO_DEPTH=16).
// Stores push expected frames into a scoreboard queue; an independent
// monitor decodes txd and compares each received frame against it.
module tb_mmio_uart_tx;

  localparam logic [63:0] BASE  = 64'h0000_0000_0001_0000;
  localparam logic [63:0] STAT  = BASE + 64'd8;
  localparam int          BAUD  = 4;
  localparam int          DEPTH = 16;
  localparam int          FRAME = 10 * BAUD;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [63:0] addr = '0;
  logic [63:0] wdata = '0;
  logic        wmem = 1'b0;
  logic [2:0]  funct3 = '0;
  logic        hit;
  logic [63:0] rdata;
  logic        txd;

  mmio_uart_tx #(
    .BASE_ADDR (BASE),
    .BAUD_DIV  (BAUD),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .addr  (addr),
    .wdata (wdata),
    .wmem  (wmem),
    .funct3(funct3),
    .hit   (hit),
    .rdata (rdata),
    .txd   (txd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    int         expStart;
    bit         contig;
  } frame_t;

  frame_t expQ[$];
  int checks = 0;
  int errors = 0;
  int framesSeen = 0;
  int prevEnd = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Drives one store for a cycle; edgeCyc is the cyc value after the
  // capturing edge.
  task automatic applyStimulus(input logic [63:0] a, input logic [63:0] d,
                               output int edgeCyc);
    addr    = a;
    wdata   = d;
    wmem    = 1'b1;
    funct3  = 3'($urandom_range(0, 7));
    edgeCyc = cyc + 1;
    @(negedge clk);
    wmem  = 1'b0;
    addr  = '0;
    wdata = '0;
  endtask

  task automatic expectFrame(input logic [7:0] d, input int start, input bit contig);
    frame_t f;
    f.data = d;
    f.expStart = start;
    f.contig = contig;
    expQ.push_back(f);
  endtask

  task automatic readStatus(input string name, input logic [63:0] expected);
    addr = STAT;
    #1;
    checkOutput(name, rdata, expected);
    addr = '0;
  endtask

  task automatic waitCyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic waitDrain(input int budget);
    int n;
    n = 0;
    while (expQ.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain within budget", 64'(expQ.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  // Monitor: samples txd every negedge, decodes a 10-bit frame once the
  // line goes low, and scores it against the head of the queue.
  initial begin : monitor
    logic [9:0] bits;
    bit         aborted, unstable;
    int         startCyc;
    frame_t     e;
    forever begin
      @(negedge clk);
      if (resetn && txd === 1'b0) begin
        startCyc = cyc;
        aborted  = 1'b0;
        unstable = 1'b0;
        bits     = '0;
        for (int b = 0; b < 10 && !aborted; b++) begin
          for (int c = 0; c < BAUD && !aborted; c++) begin
            if (!(b == 0 && c == 0)) @(negedge clk);
            if (!resetn) aborted = 1'b1;
            else if (c == 0) bits[b] = txd;
            else if (txd !== bits[b]) unstable = 1'b1;
          end
        end
        if (!aborted) begin
          framesSeen++;
          if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected frame: got %h expected none", bits[8:1]);
          end else begin
            e = expQ.pop_front();
            checkOutput("frame data", 64'(bits[8:1]), 64'(e.data));
            checkOutput("frame start/stop bits", 64'({bits[9], bits[0]}), 64'b10);
            checkOutput("frame level held per bit", 64'(unstable), 64'd0);
            if (e.contig)
              checkOutput("frame contiguous start", 64'(startCyc), 64'(prevEnd));
            else if (e.expStart >= 0)
              checkOutput("frame start cycle", 64'(startCyc), 64'(e.expStart));
          end
          prevEnd = startCyc + FRAME;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int e, e0, snap;

    // Reset values and address decode.
    repeat (3) @(negedge clk);
    checkOutput("reset txd", 64'(txd), 64'd1);
    addr = STAT; #1;
    checkOutput("reset STATUS", rdata, 64'h4);
    checkOutput("hit at STATUS", 64'(hit), 64'd1);
    addr = 64'd0; #1;
    checkOutput("hit at addr 0", 64'(hit), 64'd0);
    checkOutput("rdata at addr 0", rdata, 64'd0);
    addr = BASE; #1;
    checkOutput("hit at TXDATA", 64'(hit), 64'd1);
    checkOutput("rdata at TXDATA", rdata, 64'd0);
    addr = '0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    checkOutput("txd idle after release", 64'(txd), 64'd1);

    // Single byte 0xA5: frame starts one cycle after the store edge.
    applyStimulus(BASE, 64'hFFFF_FFFF_FFFF_FFA5, e0);
    expectFrame(8'hA5, e0 + 1, 1'b0);
    waitCyc(e0 + 10);
    readStatus("busy mid-frame STATUS", 64'h5);
    waitDrain(FRAME + 20);
    readStatus("idle after frame STATUS", 64'h4);

    // 17 back-to-back stores: 0x00 leaves at once, 0x01..0x10 fill the
    // FIFO exactly; the next store finds it full and is dropped.
    for (int i = 0; i < 17; i++) begin
      applyStimulus(BASE, 64'(i), e);
      if (i == 0) begin
        e0 = e;
        expectFrame(8'(i), e + 1, 1'b0);
      end else begin
        expectFrame(8'(i), -1, 1'b1);
      end
    end
    readStatus("full STATUS", 64'h1003);
    applyStimulus(BASE, 64'h11, e);
    readStatus("overflow STATUS", 64'h100B);
    applyStimulus(STAT, 64'h8, e);
    readStatus("overflow cleared STATUS", 64'h1003);
    waitDrain(17 * FRAME + 50);
    readStatus("idle after burst STATUS", 64'h4);

    // Push coincident with the STOP-exit pop while one byte is queued.
    applyStimulus(BASE, 64'h3C, e0);
    expectFrame(8'h3C, e0 + 1, 1'b0);
    applyStimulus(BASE, 64'hC3, e);
    expectFrame(8'hC3, -1, 1'b1);
    waitCyc(e0 + 40);
    readStatus("count 1 before STOP exit", 64'h101);
    applyStimulus(BASE, 64'h5A, e);
    expectFrame(8'h5A, -1, 1'b1);
    readStatus("count held across push+pop", 64'h101);
    waitDrain(3 * FRAME + 50);

    // Reset in the middle of DATA for a 3-byte burst.
    applyStimulus(BASE, 64'h00, e0);
    expectFrame(8'h00, e0 + 1, 1'b0);
    applyStimulus(BASE, 64'h22, e);
    expectFrame(8'h22, -1, 1'b1);
    applyStimulus(BASE, 64'h33, e);
    expectFrame(8'h33, -1, 1'b1);
    waitCyc(e0 + 1 + BAUD + 10);
    checkOutput("txd low mid-DATA", 64'(txd), 64'd0);
    #2;
    resetn = 1'b0;
    expQ.delete();
    #1;
    checkOutput("txd high on reset", 64'(txd), 64'd1);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    readStatus("STATUS after mid-frame reset", 64'h4);
    snap = framesSeen;
    repeat (200) @(negedge clk);
    checkOutput("no frames after reset", 64'(framesSeen), 64'(snap));
    checkOutput("txd idle after reset", 64'(txd), 64'd1);
    checkOutput("scoreboard empty", 64'(expQ.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
